tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-producing requesters (e.g. several ALU/interface circuits). Each requester raises a request with a byte. The arbiter grants one requester at a time, latches its byte, and drives the UART TX `tx_start`/`tx_done` handshake. It acknowledges the requester when the byte has gone out. It sits between the requesters and the UART TX module.

---
 rtl/tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. One requester is granted at a time: its byte is latched, the UART
// tx_start/tx_done handshake is driven, and the owner receives a one-cycle ack
// once the byte has gone out.
//
// Optional feature macro: TX_ARB_TIMEOUT_EN
//   defined   : an NB_TIMEOUT-bit watchdog aborts SEND after 2^NB_TIMEOUT
//               cycles without a tx_done rising edge (o_timeout pulses).
//   undefined : no watchdog; SEND waits indefinitely, o_timeout is tied to 0.
//
// Ports
//   i_clk       in   clock, rising edge
//   i_rst       in   asynchronous reset, active low
//   i_req       in   [N_REQ]          request levels, one per requester
//   i_data      in   [N_REQ*NB_BITS]  packed bytes, requester k at [k*NB_BITS +: NB_BITS]
//   o_grant     out  [N_REQ]          one-hot current owner, zero when idle
//   o_ack       out  [N_REQ]          one-cycle pulse to the owner at transfer end
//   o_data      out  [NB_BITS]        latched byte for the UART transmitter
//   o_tx_start  out  1                start level, held until a tx_done rising edge
//   i_tx_done   in   1                completion from the UART transmitter
//   o_busy      out  1                high whenever the arbiter is not idle
//   o_timeout   out  1                one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int NB_BITS    = 8,
  parameter int N_REQ      = 4,
  parameter int NB_TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_BITS-1:0] i_data,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_ack,
  output logic [NB_BITS-1:0]       o_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;  // one extra bit so last+i cannot overflow

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   ack_reg, ack_next;
  logic [NB_BITS-1:0] data_reg, data_next;
  logic               tx_start_reg, tx_start_next;
  logic               busy_reg, busy_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic               tx_done_prev_reg;

`ifdef TX_ARB_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] wdog_cnt_reg, wdog_cnt_next;
  logic                  timeout_reg, timeout_next;
`endif

  // Unpack the requester bytes so the selected one can be indexed directly.
  logic [NB_BITS-1:0] req_bytes [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = i_data[gi*NB_BITS +: NB_BITS];
    end
  endgenerate

  // Only a low-to-high transition of tx_done counts; a level that is already
  // high when SEND is entered must fall and rise again.
  logic tx_done_rise;
  assign tx_done_rise = i_tx_done & ~tx_done_prev_reg;

  // Round-robin pick: first asserted request searching from last+1 upward,
  // wrapping modulo N_REQ.
  logic [CW-1:0]    cand;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_reg} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!sel_found && i_req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    ack_next      = '0;
    data_next     = data_reg;
    tx_start_next = tx_start_reg;
    last_next     = last_reg;
    owner_next    = owner_reg;
`ifdef TX_ARB_TIMEOUT_EN
    wdog_cnt_next = wdog_cnt_reg;
    timeout_next  = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          grant_next = N_REQ'(1) << sel_idx;
          owner_next = sel_idx;
          data_next  = req_bytes[sel_idx];
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_start_next = 1'b1;
`ifdef TX_ARB_TIMEOUT_EN
        wdog_cnt_next = '0;
`endif
        state_next    = ST_SEND;
      end
      ST_SEND: begin
        // A real completion takes priority over a watchdog terminal count
        // arriving in the same cycle.
        if (tx_done_rise) begin
          tx_start_next = 1'b0;
          ack_next      = grant_reg;
          state_next    = ST_DONE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (&wdog_cnt_reg) begin
          tx_start_next = 1'b0;
          ack_next      = grant_reg;
          timeout_next  = 1'b1;
          state_next    = ST_DONE;
        end else begin
          wdog_cnt_next = wdog_cnt_reg + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        grant_next = '0;
        last_next  = owner_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= '0;
      ack_reg          <= '0;
      data_reg         <= '0;
      tx_start_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      last_reg         <= IDX_W'(N_REQ - 1);
      owner_reg        <= '0;
      tx_done_prev_reg <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      wdog_cnt_reg     <= '0;
      timeout_reg      <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      ack_reg          <= ack_next;
      data_reg         <= data_next;
      tx_start_reg     <= tx_start_next;
      busy_reg         <= busy_next;
      last_reg         <= last_next;
      owner_reg        <= owner_next;
      tx_done_prev_reg <= i_tx_done;
`ifdef TX_ARB_TIMEOUT_EN
      wdog_cnt_reg     <= wdog_cnt_next;
      timeout_reg      <= timeout_next;
`endif
    end
  end

  assign o_grant    = grant_reg;
  assign o_ack      = ack_reg;
  assign o_data     = data_reg;
  assign o_tx_start = tx_start_reg;
  assign o_busy     = busy_reg;
`ifdef TX_ARB_TIMEOUT_EN
  assign o_timeout  = timeout_reg;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//
// Directed testbench for tx_arbiter (N_REQ=4, NB_BITS=8, NB_TIMEOUT=4).
// A table of per-cycle vectors covers single transfer, round-robin order and
// data freezing; hand-written sequences cover held/stray tx_done, asynchronous
// reset mid-transfer and the watchdog (TX_ARB_TIMEOUT_EN) or its absence.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        tx_done;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  odata;
  logic        tx_start;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NB_BITS   (8),
    .N_REQ     (4),
    .NB_TIMEOUT(4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_req     (req),
    .i_data    (data),
    .o_grant   (grant),
    .o_ack     (ack),
    .o_data    (odata),
    .o_tx_start(tx_start),
    .i_tx_done (tx_done),
    .o_busy    (busy),
    .o_timeout (timeout)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic [7:0]  e_data;
    logic        e_start;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                              input logic dn, input logic [3:0] eg, input logic [3:0] ea,
                              input logic [7:0] ed, input logic es, input logic eb);
    vec_t v;
    v.rst_n = r;   v.req = rq;    v.data = d;     v.done = dn;
    v.e_grant = eg; v.e_ack = ea; v.e_data = ed;  v.e_start = es; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic [7:0] ed, input logic es, input logic eb,
                           input logic et);
    check({tag, " grant"},   32'(grant),    32'(eg));
    check({tag, " ack"},     32'(ack),      32'(ea));
    check({tag, " data"},    32'(odata),    32'(ed));
    check({tag, " start"},   32'(tx_start), 32'(es));
    check({tag, " busy"},    32'(busy),     32'(eb));
    check({tag, " timeout"}, 32'(timeout),  32'(et));
  endtask

  // Advance one cycle, then compare all outputs.
  task automatic step(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                      input logic [7:0] ed, input logic es, input logic eb,
                      input logic et);
    @(negedge clk);
    check_all(tag, eg, ea, ed, es, eb, et);
  endtask

  initial begin
    logic [31:0] bytes2;
    logic [3:0]  one_hot;
    int          g;

    rst_n   = 1'b0;
    req     = '0;
    data    = '0;
    tx_done = 1'b0;

    // ---------------- vector table ----------------
    // Single transfer, byte 0x41, tx_done pulsed 10 cycles after tx_start.
    add(1, 4'b0001, 32'h41, 0, 4'b0001, 4'b0000, 8'h41, 0, 1);
    add(1, 4'b0001, 32'h41, 0, 4'b0001, 4'b0000, 8'h41, 1, 1);
    for (int i = 0; i < 10; i++)
      add(1, 4'b0001, 32'h41, 0, 4'b0001, 4'b0000, 8'h41, 1, 1);
    add(1, 4'b0001, 32'h41, 1, 4'b0001, 4'b0001, 8'h41, 0, 1);
    add(1, 4'b0000, 32'h41, 0, 4'b0000, 4'b0000, 8'h41, 0, 0);
    add(1, 4'b0000, 32'h41, 0, 4'b0000, 4'b0000, 8'h41, 0, 0);
    // Reset so the round-robin starts from requester 0 again.
    add(0, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0);
    // All four requesting; each drops on ack and re-raises one cycle later.
    bytes2 = 32'h40302010;
    for (int t = 0; t < 5; t++) begin
      g = t % 4;
      one_hot = 4'b0001 << g;
      add(1, 4'b1111, bytes2, 0, one_hot, 4'b0000, bytes2[g*8 +: 8], 0, 1);
      add(1, 4'b1111, bytes2, 0, one_hot, 4'b0000, bytes2[g*8 +: 8], 1, 1);
      add(1, 4'b1111, bytes2, 0, one_hot, 4'b0000, bytes2[g*8 +: 8], 1, 1);
      add(1, 4'b1111, bytes2, 1, one_hot, one_hot, bytes2[g*8 +: 8], 0, 1);
      add(1, 4'b1111 & ~one_hot, bytes2, 0, 4'b0000, 4'b0000, bytes2[g*8 +: 8], 0, 0);
    end
    // Byte changes from 0x55 to 0xAA after the grant: latched value holds.
    add(1, 4'b0001, 32'h55, 0, 4'b0001, 4'b0000, 8'h55, 0, 1);
    add(1, 4'b0001, 32'hAA, 0, 4'b0001, 4'b0000, 8'h55, 1, 1);
    add(1, 4'b0001, 32'hAA, 0, 4'b0001, 4'b0000, 8'h55, 1, 1);
    add(1, 4'b0001, 32'hAA, 1, 4'b0001, 4'b0001, 8'h55, 0, 1);
    add(1, 4'b0000, 32'hAA, 0, 4'b0000, 4'b0000, 8'h55, 0, 0);

    // ---------------- reset state ----------------
    @(negedge clk);
    check_all("reset", 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
    rst_n = 1'b1;

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n   = vecs[i].rst_n;
      req     = vecs[i].req;
      data    = vecs[i].data;
      tx_done = vecs[i].done;
      @(negedge clk);
      $display("vec %0d req=%b done=%b grant=%b ack=%b data=%h start=%b busy=%b",
               i, vecs[i].req, vecs[i].done, grant, ack, odata, tx_start, busy);
      check_all($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_ack,
                vecs[i].e_data, vecs[i].e_start, vecs[i].e_busy, 1'b0);
    end
    rst_n = 1'b1;

    // ---------------- stray and held tx_done ----------------
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tx_done = (i % 2 == 0);
      step("stray", 4'b0000, 4'b0000, 8'h55, 0, 0, 0);
    end
    tx_done = 1'b1;
    req     = 4'b0100;
    data    = 32'h00770000;
    step("held grant", 4'b0100, 4'b0000, 8'h77, 0, 1, 0);
    step("held start", 4'b0100, 4'b0000, 8'h77, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      step("held high", 4'b0100, 4'b0000, 8'h77, 1, 1, 0);
    tx_done = 1'b0;
    step("held low", 4'b0100, 4'b0000, 8'h77, 1, 1, 0);
    tx_done = 1'b1;
    step("held ack", 4'b0100, 4'b0100, 8'h77, 0, 1, 0);
    req = 4'b0000;
    tx_done = 1'b0;
    step("held idle", 4'b0000, 4'b0000, 8'h77, 0, 0, 0);
    $display("held tx_done transfer: requester 2 acked");

    // ---------------- async reset mid-SEND (last is 2 here) ----------------
    req  = 4'b1011;
    data = 32'h33002211;
    step("rst grant", 4'b1000, 4'b0000, 8'h33, 0, 1, 0);
    step("rst start", 4'b1000, 4'b0000, 8'h33, 1, 1, 0);
    step("rst send", 4'b1000, 4'b0000, 8'h33, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_all("rst async", 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
    step("rst hold", 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    step("rst regrant", 4'b0001, 4'b0000, 8'h11, 0, 1, 0);
    step("rst restart", 4'b0001, 4'b0000, 8'h11, 1, 1, 0);
    tx_done = 1'b1;
    step("rst ack", 4'b0001, 4'b0001, 8'h11, 0, 1, 0);
    req = 4'b0000;
    tx_done = 1'b0;
    step("rst idle", 4'b0000, 4'b0000, 8'h11, 0, 0, 0);
    $display("reset mid-send: first grant after release to requester 0");

    // ---------------- watchdog ----------------
    req  = 4'b0010;
    data = 32'h00009900;
`ifdef TX_ARB_TIMEOUT_EN
    step("wd grant", 4'b0010, 4'b0000, 8'h99, 0, 1, 0);
    step("wd start", 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    for (int k = 1; k <= 15; k++)
      step($sformatf("wd wait%0d", k), 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    step("wd abort", 4'b0010, 4'b0010, 8'h99, 0, 1, 1);
    req = 4'b0000;
    step("wd idle", 4'b0000, 4'b0000, 8'h99, 0, 0, 0);
    $display("watchdog abort after 16 send cycles");
    // tx_done edge on the terminal-count cycle: normal completion.
    req = 4'b0010;
    step("race grant", 4'b0010, 4'b0000, 8'h99, 0, 1, 0);
    step("race start", 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    for (int k = 1; k <= 15; k++)
      step($sformatf("race wait%0d", k), 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    tx_done = 1'b1;
    step("race ack", 4'b0010, 4'b0010, 8'h99, 0, 1, 0);
    req = 4'b0000;
    tx_done = 1'b0;
    step("race idle", 4'b0000, 4'b0000, 8'h99, 0, 0, 0);
    $display("tx_done on terminal count: normal ack");
`else
    step("nowd grant", 4'b0010, 4'b0000, 8'h99, 0, 1, 0);
    step("nowd start", 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    for (int k = 1; k <= 20; k++)
      step($sformatf("nowd wait%0d", k), 4'b0010, 4'b0000, 8'h99, 1, 1, 0);
    tx_done = 1'b1;
    step("nowd ack", 4'b0010, 4'b0010, 8'h99, 0, 1, 0);
    req = 4'b0000;
    tx_done = 1'b0;
    step("nowd idle", 4'b0000, 4'b0000, 8'h99, 0, 0, 0);
    $display("no watchdog: long send completed on tx_done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
